tdm_mux_4_to_1: RTL and testbench

Four-channel time-division multiplexer that merges four valid/ready input streams onto one registered output stream, tagging each word with a 2-bit channel select (S1, S0). It is the transmit end of the 1:4 demultiplexer path: its out_data and S1/S0 drive the demultiplexer's data input I and its select lines, so each word is routed back to the channel it came from. Arbitration is round-robin, with a one-word output register and full-rate streaming.

---
 rtl/tdm_mux_4_to_1.sv | 87 ++++++++
 tb/tb_tdm_mux_4_to_1.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tdm_mux_4_to_1.sv
// Four-channel round-robin TDM multiplexer with a one-word output register and S1/S0 channel tag.
// Define TDM_MUX_PARITY_EN to add the registered even-parity output out_parity.
module tdm_mux_4_to_1 #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         in_valid,
    input  logic [4*WIDTH-1:0] in_data,
    output logic [3:0]         in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               S1,
    output logic               S0
`ifdef TDM_MUX_PARITY_EN
    ,
    output logic               out_parity
`endif
);

    // Handshake: a word moves on any edge where valid && ready are both high;
    // the output register is free when empty or being drained this cycle.
    logic [1:0]       r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [1:0]       r_sel;

    logic             w_free;
    logic             w_any;
    logic             w_take;
    logic [1:0]       w_gnt;
    logic [WIDTH-1:0] w_word;

    // Descending scan so the channel closest to r_ptr is written last and wins.
    always_comb begin
        w_gnt = 2'd0;
        w_any = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (in_valid[r_ptr + 2'(i)]) begin
                w_gnt = r_ptr + 2'(i);
                w_any = 1'b1;
            end
        end
    end

    assign w_free   = !r_out_valid || out_ready;
    assign w_take   = w_free && w_any && !rst;
    assign in_ready = w_take ? (4'b0001 << w_gnt) : 4'b0000;
    assign w_word   = in_data[32'(w_gnt) * WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sel       <= 2'd0;
        end else if (w_take) begin
            r_ptr       <= w_gnt + 2'd1;
            r_out_valid <= 1'b1;
            r_out_data  <= w_word;
            r_sel       <= w_gnt;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef TDM_MUX_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_take) begin
            r_parity <= ^w_word;
        end
    end

    assign out_parity = r_parity;
`endif

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign S1        = r_sel[1];
    assign S0        = r_sel[0];

endmodule

// File: tb/tb_tdm_mux_4_to_1.sv
// Bench for tdm_mux_4_to_1: directed vector table, then a randomized stream checked by a scoreboard.
// Define TDM_MUX_PARITY_EN to also check out_parity.
module tb_tdm_mux_4_to_1;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     in_valid;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           S1;
    logic           S0;
`ifdef TDM_MUX_PARITY_EN
    logic           out_parity;
`endif

    tdm_mux_4_to_1 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .S1        (S1),
        .S0        (S0)
`ifdef TDM_MUX_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           r;
        logic [3:0]     v;
        logic [4*W-1:0] d;
        logic           ordy;
        logic [3:0]     exp_rdy;
        logic           exp_ov;
        logic [W-1:0]   exp_od;
        logic [1:0]     exp_sel;
    } vec_t;

    localparam logic [4*W-1:0] RR = 32'hD3C2_B1A0;

    int         total = 0;
    int         bad   = 0;
    logic [W+1:0] exp_q[$];
    vec_t       vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs on the falling edge, check in_ready, run the scoreboard,
    // then let the rising edge happen and settle 1 time unit past it.
    task automatic step(input string tag, input logic r, input logic [3:0] v,
                        input logic [4*W-1:0] d, input logic ordy, input logic [3:0] exp_rdy);
        logic [W+1:0] e;
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; out_ready = ordy;
        #1;
        check($sformatf("%s_in_ready", tag), 32'(in_ready), 32'(exp_rdy));
        if (r) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("%s_unexpected_word", tag), 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("%s_word", tag), 32'({out_data, S1, S0}), 32'(e));
                end
            end
            for (int k = 0; k < 4; k++)
                if (exp_rdy[k]) exp_q.push_back({d[k*W +: W], 2'(k)});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic [4*W-1:0] d, input logic ordy,
                       input logic [3:0] er, input logic eov, input logic [W-1:0] eod, input logic [1:0] es);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.ordy = ordy;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_sel = es;
        vecs.push_back(t);
    endtask

    initial begin
        logic [1:0]     m_ptr;
        logic           m_ov;
        logic [3:0]     v;
        logic [4*W-1:0] d;
        logic           ordy;
        logic [3:0]     er;
        logic [1:0]     idx;

        rst = 1'b1; in_valid = 4'h0; in_data = '0; out_ready = 1'b0;

        // Reset with all channels valid
        add(1, 4'hF, RR, 1, 4'b0000, 0, 8'h00, 2'd0);
        add(1, 4'hF, RR, 1, 4'b0000, 0, 8'h00, 2'd0);
        // Single channel 2, back-to-back words
        add(0, 4'b0100, 32'h0011_0000, 1, 4'b0100, 1, 8'h11, 2'd2);
        add(0, 4'b0100, 32'h0022_0000, 1, 4'b0100, 1, 8'h22, 2'd2);
        add(0, 4'b0000, RR, 1, 4'b0000, 0, 8'h22, 2'd2);
        // ptr=3: channels 0 and 3 valid -> 3 first, then wrap to 0
        add(0, 4'b1001, RR, 1, 4'b1000, 1, 8'hD3, 2'd3);
        add(0, 4'b0001, RR, 1, 4'b0001, 1, 8'hA0, 2'd0);
        // Backpressure for three cycles
        add(0, 4'hF, RR, 0, 4'b0000, 1, 8'hA0, 2'd0);
        add(0, 4'hF, RR, 0, 4'b0000, 1, 8'hA0, 2'd0);
        add(0, 4'hF, RR, 0, 4'b0000, 1, 8'hA0, 2'd0);
        add(0, 4'hF, RR, 1, 4'b0010, 1, 8'hB1, 2'd1);
        add(0, 4'hF, RR, 1, 4'b0100, 1, 8'hC2, 2'd2);
        add(0, 4'hF, RR, 1, 4'b1000, 1, 8'hD3, 2'd3);
        add(0, 4'hF, RR, 1, 4'b0001, 1, 8'hA0, 2'd0);
        add(0, 4'hF, RR, 1, 4'b0010, 1, 8'hB1, 2'd1);
        // Reset while a word is held under backpressure
        add(0, 4'hF, RR, 0, 4'b0000, 1, 8'hB1, 2'd1);
        add(1, 4'hF, RR, 0, 4'b0000, 0, 8'h00, 2'd0);
        add(0, 4'b1010, RR, 1, 4'b0010, 1, 8'hB1, 2'd1);
        add(0, 4'b0000, RR, 1, 4'b0000, 0, 8'hB1, 2'd1);
        // Full-rate round robin from ptr=0
        add(1, 4'b0000, RR, 1, 4'b0000, 0, 8'h00, 2'd0);
        add(0, 4'hF, RR, 1, 4'b0001, 1, 8'hA0, 2'd0);
        add(0, 4'hF, RR, 1, 4'b0010, 1, 8'hB1, 2'd1);
        add(0, 4'hF, RR, 1, 4'b0100, 1, 8'hC2, 2'd2);
        add(0, 4'hF, RR, 1, 4'b1000, 1, 8'hD3, 2'd3);
        add(0, 4'hF, RR, 1, 4'b0001, 1, 8'hA0, 2'd0);
        add(0, 4'b0000, RR, 1, 4'b0000, 0, 8'hA0, 2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].ordy, vecs[i].exp_rdy);
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
            check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_od));
            check($sformatf("vec%0d_sel", i), 32'({S1, S0}), 32'(vecs[i].exp_sel));
`ifdef TDM_MUX_PARITY_EN
            check($sformatf("vec%0d_parity", i), 32'(out_parity), 32'(^vecs[i].exp_od));
`endif
        end
        check("table_queue_empty", 32'(exp_q.size()), 32'(0));

`ifdef TDM_MUX_PARITY_EN
        // Channel 1 words 0x07 then 0x03
        step("par0", 1, 4'b0000, '0, 1, 4'b0000);
        step("par1", 0, 4'b0010, 32'h0000_0700, 1, 4'b0010);
        check("par1_parity", 32'(out_parity), 32'(1));
        step("par2", 0, 4'b0010, 32'h0000_0300, 1, 4'b0010);
        check("par2_parity", 32'(out_parity), 32'(0));
        step("par3", 0, 4'b0000, '0, 1, 4'b0000);
`endif

        // Randomized stream against a small grant model
        step("rnd_rst", 1, 4'b0000, '0, 1, 4'b0000);
        m_ptr = 2'd0;
        m_ov  = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (c >= 390) begin
                v = 4'h0; ordy = 1'b1;
            end else begin
                v = 4'($urandom_range(0, 15));
                ordy = ($urandom_range(0, 3) != 0);
            end
            d  = {$urandom};
            er = 4'b0000;
            if (!m_ov || ordy) begin
                for (int j = 0; j < 4; j++) begin
                    idx = m_ptr + 2'(j);
                    if (er == 4'b0000 && v[idx]) er[idx] = 1'b1;
                end
            end
            step($sformatf("rnd%0d", c), 0, v, d, ordy, er);
            if (er != 4'b0000) begin
                m_ov = 1'b1;
                for (int j = 0; j < 4; j++)
                    if (er[j]) m_ptr = 2'(j) + 2'd1;
            end else if (m_ov && ordy) begin
                m_ov = 1'b0;
            end
            check($sformatf("rnd%0d_out_valid", c), 32'(out_valid), 32'(m_ov));
        end
        check("rnd_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
